// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-organised data memory for the CPU load/store port. Stores complete in
// the cycle they are sampled; loads are served by a small state machine that
// waits READ_LATENCY cycles and then returns the word with a one-cycle valid
// pulse. Bad accesses return zero with a one-cycle error pulse on reads, and
// are dropped with a one-cycle error pulse (one cycle after sampling) on writes.
//
// Parameters:
//   XLEN          data and address width
//   DEPTH         number of XLEN-bit words (power of two, 4..65536)
//   READ_LATENCY  wait cycles before read data is returned (1..15)
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_n_i       asynchronous active-low reset
//   read_i        level read request, held until data_valid_o is seen
//   write_i       store strobe, one write per sampled high cycle
//   addr_i        byte address, word index = addr_i[$clog2(DEPTH)+1:2]
//   data_i        store data
//   data_o        registered load data, holds its value between reads
//   data_valid_o  one-cycle pulse, data_o valid for the current request
//   error_o       one-cycle pulse flagging a bad access
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, addr_i[1:0] != 0 makes a request bad.
//                        When undefined, the low address bits are ignored and
//                        accesses go to the containing word.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            read_i,
    input  logic            write_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] data_o,
    output logic            data_valid_o,
    output logic            error_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_bad;
    logic [AW-1:0]   r_idx;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic [AW-1:0]   w_idx;
    logic            w_out_of_range;
    logic            w_misaligned;
    logic            w_addr_bad;
    logic            w_wr_ok;

    assign w_idx = addr_i[AW+1:2];

    // Any address bit at or above the byte span of the array means addr >= DEPTH*4.
    assign w_out_of_range = (addr_i >> (AW + 2)) != '0;

    // With the alignment check disabled the constant gate removes this term.
    assign w_misaligned = ALIGN_CHECK && (addr_i[1:0] != 2'b00);

    assign w_addr_bad = w_out_of_range | w_misaligned;

    // Stores are only accepted in IDLE; a store alongside a read is treated as
    // part of a bad read and never reaches the array.
    assign w_wr_ok = rst_n_i && (r_state == S_IDLE) && write_i && !read_i && !w_addr_bad;

    // Array has no reset: contents are undefined after power-up.
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            r_mem[w_idx] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bad        <= 1'b0;
            r_idx        <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            // Both flags are pulses: cleared unless set below on this edge.
            data_valid_o <= 1'b0;
            error_o      <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (read_i) begin
                        // Address and error status are captured at request
                        // time so the response does not depend on addr_i
                        // staying stable while waiting.
                        r_cnt   <= LAT_INIT;
                        r_bad   <= w_addr_bad | write_i;
                        r_idx   <= w_idx;
                        r_state <= S_WAIT;
                    end else if (write_i && w_addr_bad) begin
                        error_o <= 1'b1;
                    end
                end

                S_WAIT: begin
                    // Dropping the request aborts silently and wins over
                    // completion; data_o keeps its previous value.
                    if (!read_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        data_o       <= r_bad ? '0 : r_mem[r_idx];
                        data_valid_o <= 1'b1;
                        error_o      <= r_bad;
                        r_state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Forced IDLE cycle: a still-high read_i is taken as a new
                    // request on the next edge.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory with a configurable, multi-cycle read latency and a one-pulse valid handshake. It sits directly downstream of the CPU's load/store port. It consumes the CPU's store strobe, address and store data, plus a read request decoded from an LW. It returns load data with a valid pulse; the CPU stalls on that pulse. Writes complete in one cycle; reads are served by a small state machine and latency counter.

## Interface
- XLEN, 32 (from rriscv_pkg): data and address width.
- DEPTH, 256: number of XLEN-bit words; power of two, 4..65536.
- READ_LATENCY, 2: wait cycles before read data is returned; legal range 1..15.

- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- read_i  input  1  level read request; held high until data_valid_o is seen.
- write_i  input  1  store strobe; one write per sampled high cycle.
- addr_i  input  XLEN  byte address; word index = addr_i[$clog2(DEPTH)+1:2].
- data_i  input  XLEN  store data.
- data_o  output  XLEN  load data, registered.
- data_valid_o  output  1  one-cycle pulse: data_o valid for the current request.
- error_o  output  1  one-cycle pulse flagging a bad access.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - Reset: state IDLE, data_o=0, data_valid_o=0, error_o=0, counter=0. Memory array is not reset; its contents are undefined after power-up.
- A request is bad if any of the following holds:
  - addr_i >= DEPTH*4 (range check is always present).
  - read_i and write_i are both high on the same edge.
  - Misaligned address, when the alignment check is compiled in (see Configuration).
- IDLE transitions:
  - write_i=1, read_i=0, request good: mem[index] <= data_i; stay in IDLE.
  - write_i=1, request bad: write dropped; error_o pulses next cycle.
  - read_i=1: counter <= READ_LATENCY-1, latch bad flag, go to WAIT. Simultaneous read_i+write_i counts as a bad read.
- WAIT:
  - counter!=0: decrement.
  - counter==0: data_o <= bad ? 0 : mem[index]; go to RESP.
  - read_i=0 at any edge in WAIT: abort, return to IDLE, no valid pulse, data_o unchanged.
  - write_i in WAIT is ignored. It is not an error.
- RESP:
  - data_valid_o=1 for exactly this cycle.
  - error_o=1 in this cycle if the bad flag was latched.
  - Next edge returns to IDLE unconditionally. A still-high read_i there is sampled as a new request on the following IDLE edge.
- data_o holds its last value between reads.
- Read-after-write: a write at edge k is visible to a read sampled at edge k+1 or later.

## Timing
- Read latency: read_i first high in cycle 0 (sampled at edge 1) → data_valid_o and data_o valid in cycle READ_LATENCY+1.
- Back-to-back reads: minimum one IDLE cycle between RESP and the next WAIT. Throughput is one read per READ_LATENCY+2 cycles.
- Write latency: 0 wait cycles. Memory is updated at the sampling edge.
- Error pulse on a bad write: cycle after the sampling edge.
- All outputs are registered; there are no combinational input→output paths.
- Reset asserted mid-read: immediate return to IDLE with outputs cleared; no valid pulse follows release.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: addr_i[1:0]!=0 makes a request bad.
  - A bad read returns 0 with error_o.
  - A bad write is dropped with an error_o pulse.
- DMEM_ALIGN_CHECK_EN not defined: addr_i[1:0] is ignored. Accesses go to the containing word and no alignment error is raised.

## Test plan
- Reset: drive rst_n_i=0 mid-WAIT → data_o=0, data_valid_o=0, error_o=0 immediately. After release, no valid pulse appears.
- Write/read: write 0xDEADBEEF to 0x10 at cycle 0; read_i from cycle 1, READ_LATENCY=2 → data_valid_o only in cycle 4, data_o=0xDEADBEEF.
- Latency sweep: READ_LATENCY=1 and 15 → valid pulse in cycle 2 and cycle 16 respectively after read_i rises. Pulse is exactly one cycle.
- Abort: read_i high for 1 cycle then low, READ_LATENCY=3 → no data_valid_o, data_o unchanged, state back to IDLE.
- Range error: DEPTH=256, read 0x400 → data_valid_o with data_o=0, error_o=1 same cycle. A write to 0x400 → memory unchanged, error_o pulse next cycle.
- Alignment: read 0x13 after writing 0x11223344 to 0x10.
  - With DMEM_ALIGN_CHECK_EN: data_o=0 and error_o=1.
  - Without it: data_o=0x11223344 and error_o=0.
